// File: rtl/kred_multilane_reduce.sv
// Multi-lane, three-stage pipelined double K-RED reducer: out = (K*K*x) mod Q per lane,
// with a shared valid/ready handshake and stall-capable stages that collapse bubbles.
module kred_multilane_reduce #(
  parameter int Q     = 3329,
  parameter int M     = 8,
  parameter int K     = 13,
  parameter int IW    = 24,
  parameter int QW    = 12,
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IW-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*QW-1:0]   out_data,
  output logic                  busy
);

  localparam int W = IW + 2;
  localparam logic signed [W-1:0] K_S  = W'(K);
  localparam logic signed [W-1:0] Q_S  = W'(Q);
  localparam logic signed [W-1:0] Q2_S = W'(2 * Q);

  logic v1_reg, v2_reg, v3_reg;
  logic adv1, adv2, adv3;
  logic load1, load2, load3;

  assign adv3     = !v3_reg | out_ready;
  assign adv2     = !v2_reg | adv3;
  assign adv1     = !v1_reg | adv2;
  assign in_ready = adv1;

  // Data registers only capture real beats, so idle in_data never reaches out_data.
  assign load1 = adv1 & in_valid;
  assign load2 = adv2 & v1_reg;
  assign load3 = adv3 & v2_reg;

  assign out_valid = v3_reg;
  assign busy      = v1_reg | v2_reg | v3_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else begin
      if (adv1) v1_reg <= in_valid;
      if (adv2) v2_reg <= v1_reg;
      if (adv3) v3_reg <= v2_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IW-1:0]       x;
      logic signed [W-1:0] p1_reg, h1_reg, c1;
      logic signed [W-1:0] p2_reg, h2_reg, c2;
      logic [QW-1:0]       r_next, r_reg;

      assign x  = in_data[gi*IW +: IW];
      assign c1 = p1_reg - h1_reg;
      assign c2 = p2_reg - h2_reg;

      // C2 lies in (-Q, 2Q), so one conditional add or subtract lands in [0, Q).
      always_comb begin
        r_next = QW'(c2);
        if (c2[W-1])
          r_next = QW'(c2 + Q_S);
        else if (c2 >= Q_S)
          r_next = QW'(c2 - Q_S);
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          p1_reg <= '0;
          h1_reg <= '0;
          p2_reg <= '0;
          h2_reg <= '0;
          r_reg  <= '0;
        end else begin
          if (load1) begin
            p1_reg <= K_S * signed'(W'(x[M-1:0]));
            h1_reg <= signed'(W'(x >> M));
          end
          if (load2) begin
            p2_reg <= K_S * signed'(W'(c1[M-1:0]));
            h2_reg <= c1 >>> M;
          end
          if (load3)
            r_reg <= r_next;
        end
      end

      always_ff @(posedge clk) begin
        if (rst && v2_reg)
          assert (c2 > -Q_S && c2 < Q2_S);
      end

      assign out_data[gi*QW +: QW] = r_reg;
    end
  endgenerate

endmodule

// File: tb/tb_kred_multilane_reduce.sv
// Directed bench for kred_multilane_reduce: a two-lane Kyber instance and a Dilithium instance
// driven with random traffic against an independent modular-arithmetic model.
module tb_kred_multilane_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Kyber, two lanes
  logic        k_rst, k_in_valid, k_in_ready, k_out_valid, k_out_ready, k_busy;
  logic [47:0] k_in_data;
  logic [23:0] k_out_data;

  // Dilithium, one lane
  logic        d_rst, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [45:0] d_in_data;
  logic [22:0] d_out_data;

  kred_multilane_reduce #(.LANES(2)) u_kyber (
    .clk(clk), .rst(k_rst),
    .in_valid(k_in_valid), .in_ready(k_in_ready), .in_data(k_in_data),
    .out_valid(k_out_valid), .out_ready(k_out_ready), .out_data(k_out_data),
    .busy(k_busy)
  );

  kred_multilane_reduce #(.Q(8380417), .M(13), .K(1023), .IW(46), .QW(23), .LANES(1)) u_dil (
    .clk(clk), .rst(d_rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .busy(d_busy)
  );

  // Hand-computed Kyber vectors: 169*x mod 3329
  logic [23:0] kx0 [4] = '{24'd0, 24'd1, 24'd3329, 24'd16777215};
  logic [23:0] kx1 [4] = '{24'd16777215, 24'd3329, 24'd1, 24'd0};
  logic [11:0] ke0 [4] = '{12'd0, 12'd169, 12'd0, 12'd87};
  logic [11:0] ke1 [4] = '{12'd87, 12'd0, 12'd169, 12'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int w;
    int x_next;
    int sent, got, cyc;
    logic        hold;
    logic [22:0] prev;
    logic [45:0] xr;
    longint unsigned xl, e;
    longint unsigned exp_q[$];

    k_rst = 1'b0; k_in_valid = 1'b0; k_in_data = '0; k_out_ready = 1'b1;
    d_rst = 1'b0; d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", k_out_valid, 0);
    chk("rst_out_data",  k_out_data, 0);
    chk("rst_busy",      k_busy, 0);
    chk("rst_in_ready",  k_in_ready, 1);
    chk("rst_dil_valid", d_out_valid, 0);
    k_rst = 1'b1;
    d_rst = 1'b1;

    // Back-to-back beats, both lanes, out_ready high
    for (int i = 0; i < 8; i++) begin
      if (i >= 3 && i < 7) begin
        chk("b2b_valid", k_out_valid, 1);
        chk("b2b_data", k_out_data, {ke1[i-3], ke0[i-3]});
      end
      if (i < 4) begin
        k_in_valid = 1'b1;
        k_in_data  = {kx1[i], kx0[i]};
        #1;
        chk("b2b_in_ready", k_in_ready, 1);
      end else begin
        k_in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Lane independence: {lane1=16777215, lane0=1} -> {87, 169}
    k_in_valid = 1'b1;
    k_in_data  = {24'd16777215, 24'd1};
    @(negedge clk);
    k_in_valid = 1'b0;
    w = 0;
    while (!k_out_valid && w < 10) begin
      k_in_data = 48'({$urandom, $urandom});
      @(negedge clk);
      w++;
    end
    chk("lane_latency", w, 2);
    chk("lane_data", k_out_data, {12'd87, 12'd169});

    // Idle in_data must not disturb anything
    for (int i = 0; i < 4; i++) begin
      k_in_data = 48'({$urandom, $urandom});
      @(negedge clk);
      chk("idle_valid", k_out_valid, 0);
      chk("idle_data", k_out_data, {12'd87, 12'd169});
    end
    chk("idle_busy", k_busy, 0);

    // Backpressure: only three beats fit
    k_out_ready = 1'b0;
    x_next = 1;
    for (int c = 0; c < 6; c++) begin
      k_in_valid = 1'b1;
      k_in_data  = {24'd0, 24'(x_next)};
      #1;
      if (k_in_ready) x_next++;
      @(negedge clk);
    end
    chk("bp_accepted", x_next - 1, 3);
    chk("bp_in_ready", k_in_ready, 0);
    chk("bp_valid", k_out_valid, 1);
    chk("bp_hold_data", k_out_data, {12'd0, 12'd169});

    k_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (x_next <= 5) begin
        k_in_valid = 1'b1;
        k_in_data  = {24'd0, 24'(x_next)};
      end else begin
        k_in_valid = 1'b0;
      end
      #1;
      chk("drain_valid", k_out_valid, 1);
      chk("drain_data", k_out_data, {12'd0, 12'(169 * (c + 1))});
      if (k_in_valid && k_in_ready) x_next++;
      @(negedge clk);
    end
    k_in_valid = 1'b0;
    chk("drain_all_in", x_next, 6);
    chk("drain_empty", k_busy, 0);

    // Reset with two beats in flight; the beat offered during reset is dropped
    k_in_valid = 1'b1;
    k_in_data  = {24'd0, 24'd7};
    @(negedge clk);
    k_in_data  = {24'd0, 24'd8};
    @(negedge clk);
    k_rst     = 1'b0;
    k_in_data = {24'd0, 24'd9};
    @(negedge clk);
    chk("mid_rst_valid", k_out_valid, 0);
    chk("mid_rst_busy",  k_busy, 0);
    chk("mid_rst_data",  k_out_data, 0);
    chk("mid_rst_ready", k_in_ready, 1);
    k_rst     = 1'b1;
    k_in_data = {24'd0, 24'd1};
    @(negedge clk);
    k_in_valid = 1'b0;
    w = 1;
    while (!k_out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("post_rst_latency", w, 3);
    chk("post_rst_data", k_out_data, {12'd0, 12'd169});

    // Dilithium: random traffic and random out_ready against a modular model
    sent = 0; got = 0; cyc = 0; hold = 1'b0; prev = '0; xr = '0;
    while ((sent < 1000 || got < 1000) && cyc < 20000) begin
      cyc++;
      if (sent < 1000 && ($urandom % 4) != 0) begin
        if (sent == 0)      xr = 46'd1;
        else if (sent == 1) xr = 46'h3FFF_FFFF_FFFF;
        else                xr = 46'({$urandom, $urandom});
        d_in_valid = 1'b1;
        d_in_data  = xr;
      end else begin
        d_in_valid = 1'b0;
        d_in_data  = 46'({$urandom, $urandom});
      end
      d_out_ready = (($urandom % 3) != 0);
      #1;
      if (hold) chk("dil_hold", d_out_data, prev);
      hold = d_out_valid && !d_out_ready;
      prev = d_out_data;
      if (d_out_valid && d_out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $error("FAIL dil_extra: observed output %0d expected none", d_out_data);
        end else begin
          e = exp_q.pop_front();
          if (got == 0) chk("dil_x1", d_out_data, 1046529);
          chk("dil_out", d_out_data, e);
          got++;
        end
      end
      if (d_in_valid && d_in_ready) begin
        xl = 64'(xr);
        exp_q.push_back(((xl % 64'd8380417) * 64'd1046529) % 64'd8380417);
        sent++;
      end
      @(negedge clk);
    end
    chk("dil_count", got, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
